double_frame_buffer: RTL
========================

# double_frame_buffer

Parametrised double-buffered frame store: the successor to the single-bank, 1-bit-per-colour frame buffer. It holds two complete frames of CH colour channels, each PIX_W bits deep. The renderer writes into the back bank while the display scanner reads the front bank. Banks swap only at a frame boundary, so tearing cannot occur. The block also includes a hardware clear engine that fills the back bank with a constant. It sits between the pixel-generation pipeline and the VGA scan-out logic.

## Interface
- DEPTH, 307200, pixels per frame (640x480)
- ADDR_W, 20, address width; DEPTH <= 2**ADDR_W
- CH, 3, colour channels (R,G,B packed, channel 0 in LSBs)
- PIX_W, 1, bits per channel
- CLEAR_VAL, 0, CH*PIX_W-bit value written by the clear engine
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  write one pixel into back bank
- wr_addr  in  ADDR_W  write pixel address
- wr_data  in  CH*PIX_W  write pixel data
- rd_en  in  1  read request from front bank
- rd_addr  in  ADDR_W  read pixel address
- rd_data  out  CH*PIX_W  registered read data
- rd_valid  out  1  rd_data valid this cycle
- swap_req  in  1  one-cycle pulse: request bank swap at next frame_start
- frame_start  in  1  one-cycle pulse from scan-out at start of vertical blank
- swap_pending  out  1  swap requested, not yet executed
- front_sel  out  1  bank currently displayed (0 or 1); back bank = ~front_sel
- clear_req  in  1  one-cycle pulse: start filling back bank with CLEAR_VAL
- clear_busy  out  1  clear engine active
- wr_drop  out  1  one-cycle pulse: a write was discarded

## Operation
- Storage: two banks, each DEPTH words x CH*PIX_W bits. Memory contents are not reset.
- Write path: when wr_en=1, wr_addr<DEPTH and clear_busy=0, wr_data is written to bank ~front_sel at wr_addr.
  - If wr_addr>=DEPTH, or if clear_busy=1, the write is discarded and wr_drop pulses on the next cycle.
- Read path: when rd_en=1, rd_data takes bank[front_sel][rd_addr] at the next edge, and rd_valid=1.
  - If rd_addr>=DEPTH, rd_data=0 with rd_valid=1.
  - When rd_en=0, rd_valid=0 and rd_data holds its last value.
- Swap control:
  - swap_req sets swap_pending.
  - On a frame_start cycle where (swap_pending or swap_req) is true and clear_busy=0: front_sel toggles and swap_pending clears, both at that edge.
  - A swap_req arriving on the same cycle as frame_start swaps immediately.
  - A swap_req while swap_pending=1 is absorbed; only one toggle results.
  - A frame_start while clear_busy=1 does not swap. swap_pending stays set, and the swap waits for a later frame_start.
- Clear engine FSM:
  - IDLE: clear_req=1 moves to CLEAR and zeroes the counter.
  - CLEAR: writes CLEAR_VAL to bank ~front_sel at counter, one word per cycle, then increments the counter.
  - When counter=DEPTH-1 the last write occurs and the FSM returns to IDLE.
  - clear_req during CLEAR is ignored.
- clear_busy=1 exactly while the FSM is in CLEAR.
- Read traffic is unaffected by the clear engine, because the clear targets only the back bank.

## Timing
- Reset values: front_sel=0, swap_pending=0, rd_data=0, rd_valid=0, clear_busy=0, wr_drop=0, FSM=IDLE, counter=0.
- Reset asserted mid-clear aborts the clear. The back bank is left partially cleared.
- Read latency is 1 cycle: rd_en at edge N gives rd_data/rd_valid after edge N+1. Back-to-back reads give one word per cycle.
- Reads issued on the swap cycle use the old front_sel. Reads from the next cycle onward use the new front bank.
- Writes use front_sel as it stands before the edge; a write on the swap cycle lands in the old back bank.
- Clear duration: clear_busy rises the cycle after clear_req and stays high for exactly DEPTH cycles.
- wr_drop: 1 cycle, registered, one pulse per discarded write.
- The counter is ADDR_W bits wide and never wraps past DEPTH-1.

## Test plan
- Reset, then write 0x5 to addr 10 and swap on frame_start, then read addr 10 -> rd_data=0x5 one cycle after rd_en, rd_valid=1, front_sel=1.
- swap_req with no frame_start for 100 cycles -> swap_pending=1, front_sel unchanged. Next frame_start -> front_sel toggles and swap_pending=0 on the same edge.
- With DEPTH=16, clear_req -> clear_busy high for 16 cycles. A wr_en during clear gives wr_drop pulses and no write. After the clear and a swap, every address reads CLEAR_VAL.
- frame_start during clear with swap_pending=1 -> no swap. The first frame_start after clear_busy falls swaps.
- Write at wr_addr=DEPTH -> wr_drop=1 for one cycle and no memory change. Read at rd_addr=DEPTH -> rd_data=0, rd_valid=1.
- Assert rst_n low mid-clear (counter=5) -> all outputs at reset values immediately. After release, the FSM is IDLE and front_sel=0.

Source files
------------

// File: rtl/double_frame_buffer.sv
// Double-buffered frame store with tear-free bank swap and a back-bank clear engine.
// The renderer writes the back bank (~front_sel) while scan-out reads the front bank.
module double_frame_buffer #(
    parameter int DEPTH  = 307200,
    parameter int ADDR_W = 20,
    parameter int CH     = 3,
    parameter int PIX_W  = 1,
    parameter logic [CH*PIX_W-1:0] CLEAR_VAL = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [CH*PIX_W-1:0] wr_data,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [CH*PIX_W-1:0] rd_data,
    output logic                rd_valid,
    input  logic                swap_req,
    input  logic                frame_start,
    output logic                swap_pending,
    output logic                front_sel,
    input  logic                clear_req,
    output logic                clear_busy,
    output logic                wr_drop
);

    localparam int DW    = CH * PIX_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]        state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic              front_sel_reg;
    logic              swap_pending_reg;
    logic              wr_drop_reg;
    logic              rd_valid_reg;
    logic              rd_sel_reg;
    logic              rd_oob_reg;

    logic              clear_active;
    logic              back_sel;
    logic              wr_ok;
    logic              do_swap;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DW-1:0]     mem_wdata;
    logic [IDX_W-1:0]  mem_raddr;
    logic [DW-1:0]     bank_q [2];

    assign clear_active = (state_reg == ST_CLEAR);
    assign back_sel     = ~front_sel_reg;
    assign wr_ok        = wr_en && (wr_addr <= LAST_ADDR) && !clear_active;
    // Swap is held off while the clear runs so the back bank is never shown half-filled.
    assign do_swap      = frame_start && (swap_pending_reg || swap_req) && !clear_active;

    // The clear engine owns the back-bank write port while active; pixel writes are dropped then.
    assign mem_we    = clear_active || wr_ok;
    assign mem_waddr = clear_active ? cnt_reg[IDX_W-1:0] : wr_addr[IDX_W-1:0];
    assign mem_wdata = clear_active ? CLEAR_VAL : wr_data;
    assign mem_raddr = rd_addr[IDX_W-1:0];

    // Clear engine next-state: walk the counter from 0 to DEPTH-1, then return to idle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (clear_req) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            default: begin
                if (cnt_reg == LAST_ADDR) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
        endcase
    end

    // Control state: FSM, bank selection, drop pulse and read-side bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            front_sel_reg    <= 1'b0;
            swap_pending_reg <= 1'b0;
            wr_drop_reg      <= 1'b0;
            rd_valid_reg     <= 1'b0;
            rd_sel_reg       <= 1'b0;
            rd_oob_reg       <= 1'b1;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            front_sel_reg <= front_sel_reg ^ do_swap;
            if (do_swap) begin
                swap_pending_reg <= 1'b0;
            end else if (swap_req) begin
                swap_pending_reg <= 1'b1;
            end
            wr_drop_reg  <= wr_en && !wr_ok;
            rd_valid_reg <= rd_en;
            // Bank and range are latched with the read so rd_data holds when rd_en drops.
            if (rd_en) begin
                rd_sel_reg <= front_sel_reg;
                rd_oob_reg <= (rd_addr > LAST_ADDR);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : bank_g
            logic [DW-1:0] mem [0:DEPTH-1];
            logic [DW-1:0] rd_q;

            // Back-bank write port; contents are intentionally not reset.
            always_ff @(posedge clk) begin
                if (mem_we && (back_sel == 1'(gi))) begin
                    mem[mem_waddr] <= mem_wdata;
                end
            end

            // Registered read port, kept reset-free so it maps onto block RAM.
            always_ff @(posedge clk) begin
                if (rd_en) begin
                    rd_q <= mem[mem_raddr];
                end
            end

            assign bank_q[gi] = rd_q;
        end
    endgenerate

    // Out-of-range reads and the reset state both present zero.
    assign rd_data      = rd_oob_reg ? '0 : bank_q[rd_sel_reg];
    assign rd_valid     = rd_valid_reg;
    assign swap_pending = swap_pending_reg;
    assign front_sel    = front_sel_reg;
    assign clear_busy   = clear_active;
    assign wr_drop      = wr_drop_reg;

endmodule
